// File: rtl/gaussian_filter_3x3_param.sv
// Streaming 3x3 smoothing filter (bypass / Gaussian 1-2-1 / cross) with internal line buffers.
// Optional build macro GAUSS_ROUND_EN selects round-half-up instead of a truncating shift.
module gaussian_filter_3x3_param #(
   parameter int unsigned DW        = 8,
   parameter int unsigned IMG_WIDTH = 640
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pre_frame_vsync,
   input  logic          pre_frame_hsync,
   input  logic          pre_frame_valid,
   input  logic [DW-1:0] pre_img,
   input  logic [1:0]    mode,
   output logic          post_frame_vsync,
   output logic          post_frame_hsync,
   output logic          post_frame_valid,
   output logic [DW-1:0] post_img
);
   localparam int unsigned CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);

   logic          vsync_q, valid_q, vs_rise, eol;
   logic [CW-1:0] col_cnt, col_eff;
   logic [1:0]    row_cnt, row_eff, mode_r;
   logic [DW-1:0] line1 [IMG_WIDTH];
   logic [DW-1:0] line2 [IMG_WIDTH];
   logic [DW-1:0] rd1, rd2;
   logic [DW-1:0] nc [3];
   logic [DW-1:0] win [3][3];
   logic [1:0]    m1, m2, m3;
   logic [3:0]    vs_sr, hs_sr, vl_sr;
   logic [DW+1:0] g0, g1, g2;
   logic [DW:0]   cv;
   logic [DW+2:0] ch, cs;
   logic [DW+3:0] gs;
   logic [DW-1:0] byp2, byp3, g_out, c_out, res;

   // A vsync rise clears the counters before the coincident pixel uses them
   assign vs_rise = pre_frame_vsync & ~vsync_q;
   assign eol     = valid_q & ~pre_frame_valid;
   assign col_eff = vs_rise ? '0 : col_cnt;
   assign row_eff = vs_rise ? '0 : row_cnt;
   assign rd1     = line1[col_eff];
   assign rd2     = line2[col_eff];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b0;
         valid_q <= 1'b0;
         col_cnt <= '0;
         row_cnt <= '0;
         mode_r  <= 2'b01;
      end else begin
         vsync_q <= pre_frame_vsync;
         valid_q <= pre_frame_valid;
         if (vs_rise) mode_r <= mode;
         if (pre_frame_valid) col_cnt <= (col_eff == COL_MAX) ? col_eff : col_eff + 1'b1;
         else if (eol || vs_rise) col_cnt <= '0;
         if (vs_rise) row_cnt <= '0;
         else if (eol && row_cnt != 2'd3) row_cnt <= row_cnt + 1'b1;
      end
   end

   // Read-before-write: the old entry shifts down to line2 as the new pixel lands in line1
   always_ff @(posedge clk) begin
      if (pre_frame_valid) begin
         line1[col_eff] <= pre_img;
         line2[col_eff] <= rd1;
      end
   end

   always_comb begin
      nc[2] = pre_img;
      nc[1] = rd1;
      nc[0] = rd2;
      if (row_eff == 2'd0) begin
         nc[1] = pre_img;
         nc[0] = pre_img;
      end else if (row_eff == 2'd1) begin
         nc[0] = rd1;
      end
   end

   // Stage 1: window shift with left-border replication
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) win[r][c] <= '0;
         m1 <= 2'b00;
      end else begin
         m1 <= vs_rise ? mode : mode_r;
         if (pre_frame_valid) begin
            for (int r = 0; r < 3; r++) begin
               win[r][2] <= nc[r];
               win[r][1] <= (col_eff == '0) ? nc[r] : win[r][2];
               win[r][0] <= (col_eff == '0) ? nc[r] :
                            (col_eff == CW'(1)) ? win[r][2] : win[r][1];
            end
         end
      end
   end

   // Stages 2-4: row sums, total sums, mode mux and output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g0 <= '0; g1 <= '0; g2 <= '0; cv <= '0; ch <= '0; byp2 <= '0;
         gs <= '0; cs <= '0; byp3 <= '0;
         m2 <= 2'b00; m3 <= 2'b00;
         vs_sr <= '0; hs_sr <= '0; vl_sr <= '0;
         post_img <= '0;
      end else begin
         g0   <= (DW+2)'(win[0][0]) + ((DW+2)'(win[0][1]) << 1) + (DW+2)'(win[0][2]);
         g1   <= (DW+2)'(win[1][0]) + ((DW+2)'(win[1][1]) << 1) + (DW+2)'(win[1][2]);
         g2   <= (DW+2)'(win[2][0]) + ((DW+2)'(win[2][1]) << 1) + (DW+2)'(win[2][2]);
         cv   <= (DW+1)'(win[0][1]) + (DW+1)'(win[2][1]);
         ch   <= (DW+3)'(win[1][0]) + ((DW+3)'(win[1][1]) << 2) + (DW+3)'(win[1][2]);
         byp2 <= win[2][2];
         m2   <= m1;
         gs   <= (DW+4)'(g0) + ((DW+4)'(g1) << 1) + (DW+4)'(g2);
         cs   <= (DW+3)'(cv) + ch;
         byp3 <= byp2;
         m3   <= m2;
         vs_sr <= {vs_sr[2:0], pre_frame_vsync};
         hs_sr <= {hs_sr[2:0], pre_frame_hsync};
         vl_sr <= {vl_sr[2:0], pre_frame_valid};
         post_img <= vl_sr[2] ? res : '0;
      end
   end

`ifdef GAUSS_ROUND_EN
   logic [DW+4:0] g_rnd;
   logic [DW+3:0] c_rnd;
   assign g_rnd = (DW+5)'(gs) + (DW+5)'(8);
   assign c_rnd = (DW+4)'(cs) + (DW+4)'(4);
   assign g_out = DW'(g_rnd >> 4);
   assign c_out = DW'(c_rnd >> 3);
`else
   assign g_out = DW'(gs >> 4);
   assign c_out = DW'(cs >> 3);
`endif

   always_comb begin
      res = byp3;
      unique case (m3)
         2'b01:   res = g_out;
         2'b10:   res = c_out;
         default: res = byp3;
      endcase
   end

   assign post_frame_vsync = vs_sr[3];
   assign post_frame_hsync = hs_sr[3];
   assign post_frame_valid = vl_sr[3];
endmodule

// File: tb/tb_gaussian_filter_3x3_param.sv
// Directed bench for gaussian_filter_3x3_param: constant, impulse, border, mode latch,
// overlong-line and mid-frame reset frames. Expected values follow GAUSS_ROUND_EN if defined.
module tb_gaussian_filter_3x3_param;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pre_frame_vsync = 1'b0, pre_frame_hsync = 1'b0, pre_frame_valid = 1'b0;
   logic [7:0] pre_img = 8'd0;
   logic [1:0] mode = 2'b01;
   logic       post_frame_vsync, post_frame_hsync, post_frame_valid;
   logic [7:0] post_img;
   logic       vs2, hs2, vl2;
   logic [7:0] img2;

   int tests = 0;
   int failed = 0;
   logic [7:0] img [8][8];
   logic [7:0] outq[$];
   logic [7:0] outq2[$];
   logic       hv [4], hh [4], hl [4];

`ifdef GAUSS_ROUND_EN
   localparam int EXP_IMP = 13;
   localparam int EXP_B1  = 13;
`else
   localparam int EXP_IMP = 12;
   localparam int EXP_B1  = 12;
`endif

   always #5 clk = ~clk;

   gaussian_filter_3x3_param #(.DW(8), .IMG_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .pre_frame_vsync(pre_frame_vsync), .pre_frame_hsync(pre_frame_hsync),
      .pre_frame_valid(pre_frame_valid), .pre_img(pre_img), .mode(mode),
      .post_frame_vsync(post_frame_vsync), .post_frame_hsync(post_frame_hsync),
      .post_frame_valid(post_frame_valid), .post_img(post_img)
   );

   gaussian_filter_3x3_param #(.DW(8), .IMG_WIDTH(4)) dut_narrow (
      .clk(clk), .rst_n(rst_n),
      .pre_frame_vsync(pre_frame_vsync), .pre_frame_hsync(pre_frame_hsync),
      .pre_frame_valid(pre_frame_valid), .pre_img(pre_img), .mode(mode),
      .post_frame_vsync(vs2), .post_frame_hsync(hs2),
      .post_frame_valid(vl2), .post_img(img2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, sample #1 after the edge, check sync delay and zero gating
   task automatic step(input logic vs, input logic hs, input logic v, input logic [7:0] px);
      pre_frame_vsync = vs;
      pre_frame_hsync = hs;
      pre_frame_valid = v;
      pre_img = px;
      @(posedge clk);
      #1;
      for (int i = 3; i > 0; i--) begin
         hv[i] = hv[i-1]; hh[i] = hh[i-1]; hl[i] = hl[i-1];
      end
      hv[0] = vs; hh[0] = hs; hl[0] = v;
      if (!rst_n) for (int i = 0; i < 4; i++) begin
         hv[i] = 1'b0; hh[i] = 1'b0; hl[i] = 1'b0;
      end
      check("vsync_dly", 32'(post_frame_vsync), 32'(hv[3]));
      check("hsync_dly", 32'(post_frame_hsync), 32'(hh[3]));
      check("valid_dly", 32'(post_frame_valid), 32'(hl[3]));
      if (post_frame_valid) outq.push_back(post_img);
      else check("img_zero_when_invalid", 32'(post_img), 0);
      if (vl2) outq2.push_back(img2);
   endtask

   task automatic fill(input logic [7:0] val);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) img[r][c] = val;
   endtask

   // mode m0 is presented at the vsync rise; m1 is applied from row 1 onward
   task automatic send_frame(input int w, input int h, input logic [1:0] m0,
                             input logic [1:0] m1);
      outq.delete();
      outq2.delete();
      mode = m0;
      step(1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b0, 8'd0);
      for (int r = 0; r < h; r++) begin
         if (r == 1) mode = m1;
         step(1'b0, 1'b1, 1'b0, 8'd0);
         for (int c = 0; c < w; c++) step(1'b0, 1'b0, 1'b1, img[r][c]);
         step(1'b0, 1'b0, 1'b0, 8'd0);
         step(1'b0, 1'b0, 1'b0, 8'd0);
      end
      repeat (6) step(1'b0, 1'b0, 1'b0, 8'd0);
   endtask

   task automatic check_const(input string tag, input int n, input logic [7:0] val);
      check({tag, "_count"}, 32'(outq.size()), 32'(n));
      foreach (outq[i]) check({tag, "_pix"}, 32'(outq[i]), 32'(val));
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         hv[i] = 1'b0; hh[i] = 1'b0; hl[i] = 1'b0;
      end
      repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0);
      check("reset_valid", 32'(post_frame_valid), 0);
      check("reset_vsync", 32'(post_frame_vsync), 0);
      check("reset_img", 32'(post_img), 0);
      rst_n = 1'b1;
      repeat (2) step(1'b0, 1'b0, 1'b0, 8'd0);

      // Constant frame in every mode encoding
      fill(8'd100);
      send_frame(8, 4, 2'b00, 2'b00); check_const("const_bypass", 32, 8'd100);
      send_frame(8, 4, 2'b01, 2'b01); check_const("const_gauss", 32, 8'd100);
      send_frame(8, 4, 2'b10, 2'b10); check_const("const_cross", 32, 8'd100);
      send_frame(8, 4, 2'b11, 2'b11); check_const("const_mode11", 32, 8'd100);

      // Impulse, Gaussian
      fill(8'd0);
      img[2][2] = 8'd200;
      send_frame(4, 4, 2'b01, 2'b01);
      check("imp_count", 32'(outq.size()), 16);
      check("imp_g_1_1", 32'(outq[5]), 0);
      check("imp_g_2_2", 32'(outq[10]), EXP_IMP);
      check("imp_g_2_3", 32'(outq[11]), 25);
      check("imp_g_3_2", 32'(outq[14]), 25);
      check("imp_g_3_3", 32'(outq[15]), 50);

      // Impulse, bypass
      send_frame(4, 4, 2'b00, 2'b00);
      check("imp_b_2_2", 32'(outq[10]), 200);
      check("imp_b_3_3", 32'(outq[15]), 0);

      // Mode change mid-frame is ignored until the next vsync
      send_frame(4, 4, 2'b01, 2'b10);
      check("latch_g_3_3", 32'(outq[15]), 50);
      send_frame(4, 4, 2'b10, 2'b10);
      check("latch_c_2_2", 32'(outq[10]), 0);
      check("latch_c_2_3", 32'(outq[11]), 25);
      check("latch_c_3_3", 32'(outq[15]), 100);

      // Border replication on row 0
      img[0][0] = 8'd10; img[0][1] = 8'd20; img[0][2] = 8'd30; img[0][3] = 8'd40;
      send_frame(4, 1, 2'b01, 2'b01);
      check("border_count", 32'(outq.size()), 4);
      check("border_c0", 32'(outq[0]), 10);
      check("border_c1", 32'(outq[1]), EXP_B1);
      check("border_c2", 32'(outq[2]), 20);
      check("border_c3", 32'(outq[3]), 30);

      // Overlong lines on the IMG_WIDTH=4 instance
      fill(8'd100);
      send_frame(6, 2, 2'b01, 2'b01);
      check("long_count", 32'(outq2.size()), 12);
      foreach (outq2[i]) check("long_pix", 32'(outq2[i]), 100);

      // Reset mid-line, then a clean frame
      mode = 2'b01;
      step(1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b1, 1'b0, 8'd0);
      repeat (3) step(1'b0, 1'b0, 1'b1, 8'd100);
      rst_n = 1'b0;
      step(1'b0, 1'b0, 1'b1, 8'd100);
      check("midrst_valid", 32'(post_frame_valid), 0);
      check("midrst_vsync", 32'(post_frame_vsync), 0);
      check("midrst_hsync", 32'(post_frame_hsync), 0);
      check("midrst_img", 32'(post_img), 0);
      repeat (2) step(1'b0, 1'b0, 1'b1, 8'd100);
      rst_n = 1'b1;
      repeat (4) step(1'b0, 1'b0, 1'b0, 8'd0);
      send_frame(8, 4, 2'b01, 2'b01);
      check_const("after_rst", 32, 8'd100);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
